// File: rtl/tlb_array_pkg.sv
// tlb_array_pkg: shared constants and types for the joint TLB.
//   - TLBNUM / IDX_W: entry count and index width
//   - EntryHi / EntryLo field offsets in CP0 register layout
//   - tlb_page_t / tlb_entry_t: stored per-page and per-entry state
//   - page_to_lo(): rebuilds a CP0 EntryLo value from stored fields
package tlb_array_pkg;

    localparam int TLBNUM = 16;
    localparam int IDX_W  = 4;

    // EntryLo field offsets
    localparam int LO_PFN_HI = 25;
    localparam int LO_PFN_LO = 6;
    localparam int LO_C_HI   = 5;
    localparam int LO_C_LO   = 3;
    localparam int LO_D      = 2;
    localparam int LO_V      = 1;
    localparam int LO_G      = 0;

    // EntryHi field offsets
    localparam int HI_VPN2_HI = 31;
    localparam int HI_VPN2_LO = 13;
    localparam int HI_ASID_HI = 7;
    localparam int HI_ASID_LO = 0;

    typedef struct packed {
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } tlb_page_t;

    typedef struct packed {
        logic        used;
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        tlb_page_t   p0;
        tlb_page_t   p1;
    } tlb_entry_t;

    // {6'b0, pfn, c, d, v, g}: G is the entry-wide global bit on both halves
    function automatic logic [31:0] page_to_lo(tlb_page_t p, logic g);
        return {6'b0, p.pfn, p.c, p.d, p.v, g};
    endfunction

endpackage

// File: rtl/tlb_array_if.sv
// tlb_array_if: all non-clock signals of the TLB array.
//   - s0/s1: combinational translation ports (fetch, data)
//   - tlbwi_*: TLBWI write port (Index + EntryHi/Lo0/Lo1)
//   - tlbp_*: TLBP probe request and registered result
//   - r_index / tlbr_*: TLBR combinational read port
// slave = the TLB array, master = the CP0/pipeline side.
interface tlb_array_if;
    import tlb_array_pkg::*;

    logic [18:0]      s0_vpn2,  s1_vpn2;
    logic             s0_odd,   s1_odd;
    logic [7:0]       s0_asid,  s1_asid;
    logic             s0_found, s1_found;
    logic [IDX_W-1:0] s0_index, s1_index;
    logic [19:0]      s0_pfn,   s1_pfn;
    logic [2:0]       s0_c,     s1_c;
    logic             s0_d,     s1_d;
    logic             s0_v,     s1_v;

    logic             tlbwi_we;
    logic [IDX_W-1:0] w_index;
    logic [31:0]      w_entryhi, w_entrylo0, w_entrylo1;

    logic             tlbp_req;
    logic [31:0]      p_entryhi;
    logic             tlbp_index_p;
    logic [5:0]       tlbp_index_index;

    logic [IDX_W-1:0] r_index;
    logic [31:0]      tlbr_entryhi, tlbr_entrylo0, tlbr_entrylo1;

    modport slave (
        input  s0_vpn2, s0_odd, s0_asid, s1_vpn2, s1_odd, s1_asid,
        output s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
        output s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
        input  tlbwi_we, w_index, w_entryhi, w_entrylo0, w_entrylo1,
        input  tlbp_req, p_entryhi,
        output tlbp_index_p, tlbp_index_index,
        input  r_index,
        output tlbr_entryhi, tlbr_entrylo0, tlbr_entrylo1
    );

    modport master (
        output s0_vpn2, s0_odd, s0_asid, s1_vpn2, s1_odd, s1_asid,
        input  s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
        input  s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
        output tlbwi_we, w_index, w_entryhi, w_entrylo0, w_entrylo1,
        output tlbp_req, p_entryhi,
        input  tlbp_index_p, tlbp_index_index,
        output r_index,
        input  tlbr_entryhi, tlbr_entrylo0, tlbr_entrylo1
    );

endinterface

// File: rtl/tlb_array_match.sv
// tlb_match: compares one VPN2/ASID against every entry and returns the
// lowest matching index.
//   used/g/vpn2s/asids : flattened per-entry tag state
//   vpn2/asid          : lookup key
//   found/index        : hit flag and winning entry (index=0 on miss)
module tlb_match
    import tlb_array_pkg::*;
(
    input  logic [TLBNUM-1:0]        used,
    input  logic [TLBNUM-1:0]        g,
    input  logic [TLBNUM-1:0][18:0]  vpn2s,
    input  logic [TLBNUM-1:0][7:0]   asids,
    input  logic [18:0]              vpn2,
    input  logic [7:0]               asid,
    output logic                     found,
    output logic [IDX_W-1:0]         index
);

    logic [TLBNUM-1:0] hit;

    always_comb begin
        for (int i = 0; i < TLBNUM; i++) begin
            hit[i] = used[i] && (vpn2s[i] == vpn2) && (g[i] || (asids[i] == asid));
        end
    end

    // Walk from the top down so the lowest hitting index is the last write.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (hit[i]) begin
                found = 1'b1;
                index = i[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/tlb_array.sv
// tlb_array: 16-entry fully-associative MIPS32 joint TLB, 4 KB pages.
//   clk, resetn : clock, synchronous active-low reset
//   bus (slave) : s0/s1 combinational translation, TLBWI write,
//                 TLBP probe (1-cycle registered result), TLBR read.
// Writes land at posedge; searches, probes and reads in the write cycle
// therefore observe the old contents.
module tlb_array
    import tlb_array_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    tlb_array_if.slave  bus
);

    tlb_entry_t [TLBNUM-1:0] ent_q, ent_d;
    tlb_entry_t              new_ent;
    logic                    tlbp_p_q, tlbp_p_d;
    logic [5:0]              tlbp_idx_q, tlbp_idx_d;

    // Flattened tag views for the matchers
    logic [TLBNUM-1:0]       used_v, g_v;
    logic [TLBNUM-1:0][18:0] vpn2_v;
    logic [TLBNUM-1:0][7:0]  asid_v;

    for (genvar i = 0; i < TLBNUM; i++) begin : g_flat
        assign used_v[i] = ent_q[i].used;
        assign g_v[i]    = ent_q[i].g;
        assign vpn2_v[i] = ent_q[i].vpn2;
        assign asid_v[i] = ent_q[i].asid;
    end

    logic             s0_found, s1_found, p_found;
    logic [IDX_W-1:0] s0_idx,   s1_idx,   p_idx;

    tlb_match u_match_s0 (
        .used(used_v), .g(g_v), .vpn2s(vpn2_v), .asids(asid_v),
        .vpn2(bus.s0_vpn2), .asid(bus.s0_asid),
        .found(s0_found), .index(s0_idx)
    );

    tlb_match u_match_s1 (
        .used(used_v), .g(g_v), .vpn2s(vpn2_v), .asids(asid_v),
        .vpn2(bus.s1_vpn2), .asid(bus.s1_asid),
        .found(s1_found), .index(s1_idx)
    );

    tlb_match u_match_p (
        .used(used_v), .g(g_v), .vpn2s(vpn2_v), .asids(asid_v),
        .vpn2(bus.p_entryhi[HI_VPN2_HI:HI_VPN2_LO]),
        .asid(bus.p_entryhi[HI_ASID_HI:HI_ASID_LO]),
        .found(p_found), .index(p_idx)
    );

    // Entry image built from the CP0 registers for TLBWI
    always_comb begin
        new_ent        = '0;
        new_ent.used   = 1'b1;
        new_ent.vpn2   = bus.w_entryhi[HI_VPN2_HI:HI_VPN2_LO];
        new_ent.asid   = bus.w_entryhi[HI_ASID_HI:HI_ASID_LO];
        new_ent.g      = bus.w_entrylo0[LO_G] & bus.w_entrylo1[LO_G];
        new_ent.p0.pfn = bus.w_entrylo0[LO_PFN_HI:LO_PFN_LO];
        new_ent.p0.c   = bus.w_entrylo0[LO_C_HI:LO_C_LO];
        new_ent.p0.d   = bus.w_entrylo0[LO_D];
        new_ent.p0.v   = bus.w_entrylo0[LO_V];
        new_ent.p1.pfn = bus.w_entrylo1[LO_PFN_HI:LO_PFN_LO];
        new_ent.p1.c   = bus.w_entrylo1[LO_C_HI:LO_C_LO];
        new_ent.p1.d   = bus.w_entrylo1[LO_D];
        new_ent.p1.v   = bus.w_entrylo1[LO_V];
    end

    always_comb begin
        ent_d = ent_q;
        if (bus.tlbwi_we) begin
            ent_d[bus.w_index] = new_ent;
        end
    end

    // Probe result is taken from the pre-write array and held until the
    // next request; the matcher already reports index 0 on a miss.
    always_comb begin
        tlbp_p_d   = tlbp_p_q;
        tlbp_idx_d = tlbp_idx_q;
        if (bus.tlbp_req) begin
            tlbp_p_d   = ~p_found;
            tlbp_idx_d = {{(6 - IDX_W){1'b0}}, p_idx};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ent_q      <= '0;
            tlbp_p_q   <= 1'b0;
            tlbp_idx_q <= '0;
        end else begin
            ent_q      <= ent_d;
            tlbp_p_q   <= tlbp_p_d;
            tlbp_idx_q <= tlbp_idx_d;
        end
    end

    // Search data comes from the same entry the encoder picked; on a miss
    // the whole page is forced to zero.
    tlb_page_t s0_page, s1_page;

    always_comb begin
        s0_page = '0;
        if (s0_found) begin
            s0_page = bus.s0_odd ? ent_q[s0_idx].p1 : ent_q[s0_idx].p0;
        end
    end

    always_comb begin
        s1_page = '0;
        if (s1_found) begin
            s1_page = bus.s1_odd ? ent_q[s1_idx].p1 : ent_q[s1_idx].p0;
        end
    end

    assign bus.s0_found = s0_found;
    assign bus.s0_index = s0_idx;
    assign bus.s0_pfn   = s0_page.pfn;
    assign bus.s0_c     = s0_page.c;
    assign bus.s0_d     = s0_page.d;
    assign bus.s0_v     = s0_page.v;

    assign bus.s1_found = s1_found;
    assign bus.s1_index = s1_idx;
    assign bus.s1_pfn   = s1_page.pfn;
    assign bus.s1_c     = s1_page.c;
    assign bus.s1_d     = s1_page.d;
    assign bus.s1_v     = s1_page.v;

    assign bus.tlbp_index_p     = tlbp_p_q;
    assign bus.tlbp_index_index = tlbp_idx_q;

    tlb_entry_t r_ent;
    assign r_ent = ent_q[bus.r_index];

    assign bus.tlbr_entryhi  = {r_ent.vpn2, 5'b0, r_ent.asid};
    assign bus.tlbr_entrylo0 = page_to_lo(r_ent.p0, r_ent.g);
    assign bus.tlbr_entrylo1 = page_to_lo(r_ent.p1, r_ent.g);

    // Register bits the TLB does not store
    logic unused_bits;
    assign unused_bits = ^{bus.w_entryhi[12:8], bus.w_entrylo0[31:26],
                           bus.w_entrylo1[31:26], bus.p_entryhi[12:8]};

endmodule
